// File: rtl/div32_seq.sv
// div32_seq: sequential 32-bit restoring divider for the DIV/DIVU path.
// Produces one quotient bit per cycle. Each trial subtraction goes through
// one cla32 adder in subtract mode: the divisor is inverted and cin=1.
// An operation takes 34 cycles, counting the start cycle as cycle 1.
//
// Ports:
//   clk         : clock; all state changes on the rising edge
//   resetn      : synchronous active-low reset
//   start       : request a division; only sampled while idle
//   is_signed   : 1 = DIV (two's complement), 0 = DIVU; captured with start
//   dividend    : captured with start
//   divisor     : captured with start
//   busy        : high from the accepting edge until done
//   done        : one-cycle pulse when the results are valid
//   quotient    : registered quotient (LO); held until the next done
//   remainder   : registered remainder (HI); held until the next done
//   div_by_zero : registered divide-by-zero flag; held until the next done

module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  // Carries use 4-bit lookahead groups. Each group carry-out comes from the
  // group generate/propagate terms, so nothing ripples bit by bit.
  function automatic logic [32:0] carry_chain(input logic [31:0] p,
                                              input logic [31:0] g,
                                              input logic        c0);
    logic [32:0] c;
    logic        gg;
    logic        pp;
    int          b;
    c    = '0;
    c[0] = c0;
    for (int k = 0; k < 8; k++) begin
      b  = 4 * k;
      gg = g[b+3] | (p[b+3] & g[b+2]) | (p[b+3] & p[b+2] & g[b+1]) |
           (p[b+3] & p[b+2] & p[b+1] & g[b]);
      pp = p[b+3] & p[b+2] & p[b+1] & p[b];
      c[b+1] = g[b] | (p[b] & c[b]);
      c[b+2] = g[b+1] | (p[b+1] & g[b]) | (p[b+1] & p[b] & c[b]);
      c[b+3] = g[b+2] | (p[b+2] & g[b+1]) | (p[b+2] & p[b+1] & g[b]) |
               (p[b+2] & p[b+1] & p[b] & c[b]);
      c[b+4] = gg | (pp & c[b]);
    end
    return c;
  endfunction

  logic [31:0] p;
  logic [31:0] g;
  logic [32:0] c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = carry_chain(p, g, cin);
    sum  = p ^ c[31:0];
    cout = c[32];
  end

endmodule

module div32_seq (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // The partial remainder is always below the divisor, so its 33rd bit is
  // always zero. Only the low 32 bits are kept.
  logic [31:0] r_q, r_d;
  logic [31:0] q_q, q_d;
  logic [31:0] dvs_q, dvs_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        dz_q, dz_d;
  logic        done_q, done_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic        dbz_q, dbz_d;

  logic [32:0] t;
  logic [31:0] dvs_n;
  logic [31:0] sub_lo;
  logic        sub_cout;
  logic        sub_ge;

  // Trial subtraction T - |divisor|. Bit 32 of T has no partner bit in the
  // divisor, so the difference is non-negative if T[32] is set or the low
  // word produces no borrow (cout=1).
  assign t      = {r_q, q_q[31]};
  assign dvs_n  = ~dvs_q;
  assign sub_ge = t[32] | sub_cout;

  cla32 u_sub (
    .a    (t[31:0]),
    .b    (dvs_n),
    .cin  (1'b1),
    .sum  (sub_lo),
    .cout (sub_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          cnt_d   = 5'd0;
          r_d     = 32'd0;
          q_d     = (is_signed & dividend[31]) ? neg32(dividend) : dividend;
          dvs_d   = (is_signed & divisor[31])  ? neg32(divisor)  : divisor;
          q_neg_d = is_signed & (dividend[31] ^ divisor[31]);
          r_neg_d = is_signed & dividend[31];
          dz_d    = (divisor == 32'd0);
        end
      end
      S_CALC: begin
        r_d   = sub_ge ? sub_lo : t[31:0];
        q_d   = {q_q[30:0], sub_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        // A zero divisor makes every trial succeed, so R ends up as
        // |dividend|. Restoring the sign then gives back the original
        // dividend. Only the quotient has to be forced.
        quot_d  = dz_q ? 32'hFFFF_FFFF : (q_neg_q ? neg32(q_q) : q_q);
        rem_d   = r_neg_q ? neg32(r_q) : r_q;
        dbz_d   = dz_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      r_q     <= 32'd0;
      q_q     <= 32'd0;
      dvs_q   <= 32'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= 32'd0;
      rem_q   <= 32'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// Directed testbench for div32_seq. Every expected value below was worked
// out by hand from the divider's result conventions.

module tb_div32_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_chk  = 0;
  int n_pass = 0;

  div32_seq dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Waits up to 60 edges for done. Returns the edge count (99 on timeout).
  task automatic wait_done(output int lat);
    lat = 99;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  // Issues one start pulse and waits for done. Latency is counted in edges
  // after the accepting edge (33 means done is seen in cycle 34).
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
    is_signed = sgn; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bcnt = busy ? 1 : 0;
    lat  = 99;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic do_case(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input logic edz);
    int lat, bcnt;
    run_div(sgn, a, b, lat, bcnt);
    chk({tag, "_lat"}, 32'(lat), 32'd33);
    chk({tag, "_busycycles"}, 32'(bcnt), 32'd33);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_quot"}, quotient, eq);
    chk({tag, "_rem"}, remainder, er);
    chk({tag, "_dz"}, {31'd0, div_by_zero}, {31'd0, edz});
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_quot_hold"}, quotient, eq);
  endtask

  initial begin
    int lat;
    int ndone;
    resetn = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quot", quotient, 32'd0);
    chk("rst_rem", remainder, 32'd0);
    chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    do_case("u100_7",    1'b0, 32'd100,       32'd7,          32'd14,        32'd2,         1'b0);
    do_case("s_m7_2",    1'b1, 32'hFFFFFFF9,  32'd2,          32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0);
    do_case("s_7_m2",    1'b1, 32'd7,         32'hFFFFFFFE,   32'hFFFFFFFD,  32'd1,         1'b0);
    do_case("s_ovf",     1'b1, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,  32'd0,         1'b0);
    do_case("u_max_1",   1'b0, 32'hFFFFFFFF,  32'd1,          32'hFFFFFFFF,  32'd0,         1'b0);
    do_case("u_3_max",   1'b0, 32'd3,         32'hFFFFFFFF,   32'd0,         32'd3,         1'b0);
    do_case("s_dz",      1'b1, 32'hFFFFFFFB,  32'd0,          32'hFFFFFFFF,  32'hFFFFFFFB,  1'b1);

    // 50/5, with 9/3 requested at cycle 10 while busy, which must be ignored.
    is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    chk("ign_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    chk("ign_lat", 32'(lat), 32'd24);
    chk("ign_quot", quotient, 32'd10);
    chk("ign_rem", remainder, 32'd0);
    // start in the done cycle is accepted
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(lat);
    chk("b2b_lat", 32'(lat), 32'd33);
    chk("b2b_quot", quotient, 32'd3);
    chk("b2b_rem", remainder, 32'd0);
    @(posedge clk); #1;
    chk("b2b_done_pulse", {31'd0, done}, 32'd0);

    // Reset during iteration 10 aborts the operation.
    is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);
    chk("mid_quot", quotient, 32'd0);
    chk("mid_rem", remainder, 32'd0);
    chk("mid_dz", {31'd0, div_by_zero}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("mid_no_done", 32'(ndone), 32'd0);
    do_case("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
